xbee_uart_rx: RTL and testbench

// - Receive side of the XBee serial link: 8N1 UART receiver, LSB first, idle-high line.
// - Sits between the XBee DOUT pin and the command/data logic.
// - Counterpart of the transmit path; uses the same bit period, default 5208 clk at 50 MHz = 9600 baud.
// - Samples each bit at its centre using a built-in half-bit / full-bit counter.

---
 rtl/xbee_uart_rx.sv | 126 ++++++++++++
 tb/tb_xbee_uart_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/xbee_uart_rx.sv
// 8N1 UART receiver for the XBee DOUT line: two-flop synchronizer, centre-of-bit sampling.
// Latency: byte appears HALF_BIT+9*CLKS_PER_BIT+1 cycles after the synchronized start edge; no backpressure.
module xbee_uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [13:0] BIT_LAST  = 14'(CLKS_PER_BIT - 1);
    localparam logic [13:0] HALF_LAST = 14'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t      state;
    logic        rx_q;
    logic        rx_s;
    logic [13:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q       <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            sh         <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_q       <= rx;
            rx_s       <= rx_q;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                // A start bit that is high again at its centre is treated as a glitch.
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 14'd1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        sh  <= {rx_s, sh[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 14'd1;
                    end
                end

                // Returning to IDLE at the stop-bit centre leaves half a bit to catch the next start edge.
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_out   <= sh;
                            data_valid <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
                    end else begin
                        cnt <= cnt + 14'd1;
                    end
                end

                BRK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbee_uart_rx.sv
// Randomized scoreboard bench for xbee_uart_rx: frames are modelled as whole bytes with
// an expected outcome and arrival cycle; a negedge monitor checks every output pulse.
module tb_xbee_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = 8;
    // Two synchronizer cycles, then half a bit plus nine bits, plus the registered output.
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    xbee_uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          ferr;
        logic [7:0]  data;
        int unsigned at;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_last = 8'h00;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one complete frame and records what the receiver should report for it.
    task automatic send_frame(input logic [7:0] b, input bit stop);
        exp_t e;
        e.ferr = !stop;
        e.data = b;
        e.at   = cyc + LAT;
        sb.push_back(e);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
    endtask

    always @(negedge clk) begin
        if (!rst && (data_valid || frame_err)) begin
            exp_t e;
            if (data_valid && frame_err) begin
                chk("both_pulses", 32'd1, 32'd0);
            end else if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, frame_err, data_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", {31'd0, frame_err}, {31'd0, e.ferr});
                chk("pulse_cycle", cyc, e.at);
                if (e.ferr) begin
                    chk("data_hold", {24'd0, data_out}, {24'd0, model_last});
                end else begin
                    chk("data_out", {24'd0, data_out}, {24'd0, e.data});
                    model_last = e.data;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int gap;
        bit stop;
        logic [7:0] b;

        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick(5);

        send_frame(8'hA5, 1'b1);
        tick(10);
        chk("busy_after_a5", {31'd0, busy}, 32'd0);
        chk("data_a5_held", {24'd0, data_out}, 32'h0000_00A5);

        // Short low pulse: rejected at the start-bit centre.
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(6);
        chk("glitch_busy", {31'd0, busy}, 32'd1);
        tick(30);
        chk("glitch_idle", {31'd0, busy}, 32'd0);
        chk("glitch_data", {24'd0, data_out}, 32'h0000_00A5);

        send_frame(8'h3C, 1'b0);
        rx = 1'b1;
        tick(10);
        chk("ferr_busy", {31'd0, busy}, 32'd0);
        chk("ferr_data", {24'd0, data_out}, 32'h0000_00A5);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(10);

        // Reset in the middle of bit 4 of 0x55.
        b = 8'h55;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = b[4];
        tick(CPB / 2);
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        rst = 1'b0;
        model_last = 8'h00;
        tick(2);
        chk("midrst_data", {24'd0, data_out}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_queue", sb.size(), 32'd0);
        send_frame(8'h81, 1'b1);
        tick(10);

        // Break: line low for 30 bit times yields a single frame error.
        begin
            exp_t e;
            e.ferr = 1'b1;
            e.data = 8'h00;
            e.at   = cyc + LAT;
            sb.push_back(e);
        end
        rx = 1'b0;
        tick(30 * CPB);
        chk("break_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        tick(5);
        chk("break_released", {31'd0, busy}, 32'd0);

        for (int k = 0; k < 24; k++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            send_frame(b, stop);
            rx  = 1'b1;
            gap = stop ? $urandom_range(0, 6) : $urandom_range(2, 6);
            if (gap > 0) tick(gap);
        end

        rx = 1'b1;
        for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
        chk("scoreboard_drained", sb.size(), 32'd0);
        tick(20);
        chk("final_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
